// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs the sync FIFO byte stream into 32-bit little-endian words with byte enables
module fifo_word_packer #(
  parameter int IN_WIDTH      = 8,
  parameter int BYTES         = 4,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_empty,
  output logic                      fifo_r_en,
  input  logic [IN_WIDTH-1:0]       fifo_data,
  input  logic                      flush_req,
  output logic [IN_WIDTH*BYTES-1:0] out_data,
  output logic [BYTES-1:0]          out_be,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               word_count
);

  localparam int          CNT_W = $clog2(BYTES + 1);
  localparam int          W     = IN_WIDTH * BYTES;
  localparam logic [15:0] TMO   = 16'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_EMIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_eff, acc_cnt_nx;
  logic [CNT_W:0]   fill_sum;
  logic [W-1:0]     acc, acc_masked;
  logic [BYTES-1:0] be_mask;
  logic             rd_pend, slot_free, unload, timed_out, flush_trig, idle_cond;
  logic [15:0]      idle_cnt;

  // A landing byte goes to lane acc_cnt_eff, so a full word unloading this
  // cycle frees lane 0 for the byte arriving alongside it.
  always_comb begin
    slot_free   = !out_valid || out_ready;
    unload      = slot_free && ((acc_cnt == CNT_W'(BYTES)) ||
                                (state == S_EMIT && acc_cnt != '0));
    acc_cnt_eff = unload ? '0 : acc_cnt;
    acc_cnt_nx  = acc_cnt_eff + CNT_W'(rd_pend);
    fill_sum    = {1'b0, acc_cnt_eff} + {{CNT_W{1'b0}}, rd_pend};
    fifo_r_en   = !rst && !fifo_empty && (state == S_FILL) &&
                  (fill_sum < (CNT_W+1)'(BYTES));
    timed_out   = (FLUSH_TIMEOUT != 0) && (idle_cnt == TMO);
    flush_trig  = flush_req || timed_out;
    idle_cond   = (state == S_FILL) && fifo_empty && !rd_pend && (acc_cnt != '0);
  end

  always_comb begin
    be_mask    = '0;
    acc_masked = '0;
    for (int i = 0; i < BYTES; i++) begin
      be_mask[i] = CNT_W'(i) < acc_cnt;
      acc_masked[i*IN_WIDTH +: IN_WIDTH] = be_mask[i] ? acc[i*IN_WIDTH +: IN_WIDTH] : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FILL: begin
        if (flush_trig && (acc_cnt != '0 || rd_pend)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!rd_pend) state_nx = (acc_cnt_eff == '0) ? S_FILL : S_EMIT;
      end
      S_EMIT: begin
        if (unload || acc_cnt == '0) state_nx = S_FILL;
      end
      default: state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FILL;
      acc_cnt    <= '0;
      acc        <= '0;
      rd_pend    <= 1'b0;
      idle_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_be     <= '0;
      word_count <= '0;
    end else begin
      state   <= state_nx;
      rd_pend <= fifo_r_en;
      acc_cnt <= acc_cnt_nx;
      for (int i = 0; i < BYTES; i++) begin
        if (rd_pend && acc_cnt_eff == CNT_W'(i)) acc[i*IN_WIDTH +: IN_WIDTH] <= fifo_data;
      end

      // Saturating idle timer; it only runs while a partial word sits starved.
      if (rd_pend || acc_cnt == '0) idle_cnt <= '0;
      else if (idle_cond && idle_cnt != TMO) idle_cnt <= idle_cnt + 16'd1;

      if (unload) begin
        out_data  <= acc_masked;
        out_be    <= be_mask;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer with FIFO model and byte scoreboard
module tb_fifo_word_packer;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_r_en;
  logic [7:0]  fifo_data = 8'h00;
  logic        flush_req = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] word_count;

  fifo_word_packer #(.IN_WIDTH(8), .BYTES(4), .FLUSH_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_data(fifo_data), .flush_req(flush_req), .out_data(out_data),
    .out_be(out_be), .out_valid(out_valid), .out_ready(out_ready),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  fq[$];
  logic [7:0]  ex[$];
  logic [35:0] rx[$];
  logic        take_s = 1'b0;
  logic        prev_stall = 1'b0;
  logic [35:0] prev_word = '0;
  int          hold_viol = 0;
  int          empty_viol = 0;

  typedef struct {
    int          nb;
    logic [63:0] b;
    bit          use_flush;
    int          nw;
    logic [95:0] d;
    logic [11:0] be;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_req = 1'b0;
    fq.delete();
    repeat (2) tick();
    rx.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_rx(input string name, input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(rx.size()), 32'(n));
  endtask

  task automatic wait_ren(input string name, input int n);
    int seen = 0;
    int k = 0;
    while (seen < n && k < 200) begin
      @(negedge clk);
      if (fifo_r_en) seen++;
      k++;
    end
    check(name, 32'(seen), 32'(n));
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  // Monitor: FIFO read capture, transfer log, output-hold and read-while-empty checks.
  always @(negedge clk) begin
    take_s = fifo_r_en && !fifo_empty;
    if (fifo_r_en && fifo_empty) empty_viol++;
    if (prev_stall && !rst && (!out_valid || {out_be, out_data} !== prev_word)) hold_viol++;
    prev_stall = out_valid && !out_ready && !rst;
    prev_word  = {out_be, out_data};
    if (!rst && out_valid && out_ready) rx.push_back({out_be, out_data});
  end

  // FIFO model: registered read data appears the cycle after an accepted read.
  always begin
    @(posedge clk);
    #1;
    if (take_s && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, last, rise, k, lat;
    logic [31:0] ew;
    logic ok;

    vt[0] = '{nb:8, b:64'h8877665544332211, use_flush:1'b0, nw:2,
              d:{32'h0, 32'h88776655, 32'h44332211}, be:{4'h0, 4'hF, 4'hF}};
    vt[1] = '{nb:3, b:64'h0000000000C3B2A1, use_flush:1'b0, nw:1,
              d:96'h00C3B2A1, be:12'h007};
    vt[2] = '{nb:2, b:64'h0000000000000201, use_flush:1'b1, nw:1,
              d:96'h00000201, be:12'h003};
    vt[3] = '{nb:5, b:64'h0000005040302010, use_flush:1'b1, nw:2,
              d:{32'h0, 32'h00000050, 32'h40302010}, be:12'h01F};
    vt[4] = '{nb:1, b:64'h000000000000005A, use_flush:1'b0, nw:1,
              d:96'h0000005A, be:12'h001};
    vt[5] = '{nb:7, b:64'h00EEDDCCBBAA9988, use_flush:1'b1, nw:2,
              d:{32'h0, 32'h00EEDDCC, 32'hBBAA9988}, be:12'h07F};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_be", 32'(out_be), 32'h0);
    check("rst_wc", 32'(word_count), 32'h0);
    check("rst_ren", 32'(fifo_r_en), 32'h0);
    do_reset();

    // Table-driven vectors
    for (int v = 0; v < 6; v++) begin
      base = rx.size();
      for (int j = 0; j < vt[v].nb; j++) fq.push_back(vt[v].b[8*j +: 8]);
      if (vt[v].use_flush) begin
        k = 0;
        while (fq.size() != 0 && k < 50) begin
          tick();
          k++;
        end
        repeat (2) tick();
        pulse_flush();
      end
      wait_rx($sformatf("vec%0d_words", v), base + vt[v].nw, 60);
      repeat (12) tick();
      check($sformatf("vec%0d_no_extra", v), 32'(rx.size()), 32'(base + vt[v].nw));
      for (int w = 0; w < vt[v].nw; w++) begin
        if (base + w < rx.size()) begin
          check($sformatf("vec%0d_w%0d_data", v, w), rx[base+w][31:0], vt[v].d[32*w +: 32]);
          check($sformatf("vec%0d_w%0d_be", v, w), 32'(rx[base+w][35:32]), 32'(vt[v].be[4*w +: 4]));
        end
      end
      check($sformatf("vec%0d_wc", v), 32'(word_count), 32'(rx.size()));
    end

    // Timeout latency: word must wait for T idle cycles, then appear promptly
    base = rx.size();
    fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
    n = 0; last = -1; rise = -1;
    while (n < 100 && rise < 0) begin
      @(negedge clk);
      if (fifo_r_en) last = n;
      if (out_valid) rise = n;
      n++;
    end
    lat = rise - last;
    ok = (rise >= 0) && (lat >= T + 3) && (lat <= T + 6);
    check("tmo_latency_ok", 32'(ok), 32'h1);
    tick();
    wait_rx("tmo_word", base + 1, 20);
    if (rx.size() > base) begin
      check("tmo_data", rx[base][31:0], 32'h00C3B2A1);
      check("tmo_be", 32'(rx[base][35:32]), 32'h7);
    end

    // Flush one cycle after the last read: drain waits for the landing byte
    repeat (4) tick();
    base = rx.size();
    fq.push_back(8'h01); fq.push_back(8'h02);
    wait_ren("flush_ren2", 2);
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    while (n < 20 && !out_valid) begin
      @(negedge clk);
      n++;
    end
    check("flush_latency_ok", 32'(n <= 4), 32'h1);
    tick();
    wait_rx("flush_word", base + 1, 20);
    if (rx.size() > base) begin
      check("flush_data", rx[base][31:0], 32'h00000201);
      check("flush_be", 32'(rx[base][35:32]), 32'h3);
    end

    // Flush with nothing buffered produces nothing
    repeat (15) tick();
    base = rx.size();
    pulse_flush();
    repeat (12) tick();
    check("empty_flush_words", 32'(rx.size()), 32'(base));
    check("empty_flush_wc", 32'(word_count), 32'(rx.size()));

    // Backpressure: 12 bytes with out_ready low for 20 cycles
    out_ready = 1'b0;
    base = rx.size();
    for (int j = 0; j < 12; j++) fq.push_back(8'h31 + 8'(j));
    repeat (20) tick();
    check("stall_fifo_left", 32'(fq.size()), 32'd4);
    check("stall_ren", 32'(fifo_r_en), 32'h0);
    check("stall_valid", 32'(out_valid), 32'h1);
    check("stall_data", out_data, 32'h34333231);
    out_ready = 1'b1;
    wait_rx("stall_words", base + 3, 60);
    for (int w = 0; w < 3; w++) begin
      if (base + w < rx.size()) begin
        ew = {8'h34 + 8'(4*w), 8'h33 + 8'(4*w), 8'h32 + 8'(4*w), 8'h31 + 8'(4*w)};
        check($sformatf("stall_w%0d_data", w), rx[base+w][31:0], ew);
        check($sformatf("stall_w%0d_be", w), 32'(rx[base+w][35:32]), 32'hF);
      end
    end
    check("hold_stable", 32'(hold_viol), 32'h0);

    // Reset mid-word (two bytes landed, third in flight)
    repeat (15) tick();
    fq.push_back(8'hD1); fq.push_back(8'hD2); fq.push_back(8'hD3); fq.push_back(8'hD4);
    wait_ren("rst_ren3", 3);
    tick();
    rst = 1'b1;
    fq.delete();
    @(negedge clk);
    check("midrst_ren", 32'(fifo_r_en), 32'h0);
    tick();
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", out_data, 32'h0);
    check("midrst_be", 32'(out_be), 32'h0);
    check("midrst_wc", 32'(word_count), 32'h0);
    tick();
    rx.delete();
    rst = 1'b0;
    tick();
    fq.push_back(8'h55); fq.push_back(8'h66);
    repeat (5) tick();
    pulse_flush();
    wait_rx("postrst_word", 1, 30);
    if (rx.size() > 0) begin
      check("postrst_data", rx[0][31:0], 32'h00006655);
      check("postrst_be", 32'(rx[0][35:32]), 32'h3);
    end

    // Randomized traffic against a byte-stream scoreboard
    do_reset();
    ex.delete();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) begin
        ew[7:0] = 8'($urandom);
        fq.push_back(ew[7:0]);
        ex.push_back(ew[7:0]);
      end
      out_ready = ($urandom_range(3) != 0);
      flush_req = ($urandom_range(39) == 0);
      tick();
    end
    flush_req = 1'b0;
    out_ready = 1'b1;
    repeat (100) tick();
    for (int w = 0; w < rx.size(); w++) begin
      ok = (rx[w][35:32] == 4'h1) || (rx[w][35:32] == 4'h3) ||
           (rx[w][35:32] == 4'h7) || (rx[w][35:32] == 4'hF);
      check($sformatf("rnd_w%0d_be_shape", w), 32'(ok), 32'h1);
      ew = '0;
      for (int l = 0; l < 4; l++) begin
        if (rx[w][32+l] && ex.size() > 0) ew[8*l +: 8] = ex.pop_front();
      end
      check($sformatf("rnd_w%0d_data", w), rx[w][31:0], ew);
    end
    check("rnd_bytes_left", 32'(ex.size()), 32'h0);
    check("rnd_wc", 32'(word_count), 32'(rx.size()));
    check("ren_while_empty", 32'(empty_viol), 32'h0);
    check("rnd_hold_stable", 32'(hold_viol), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
